serial_subtractor: RTL

- Bit-serial two's-complement subtractor. It is the inverse of the team's 4-bit ripple adder: it computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Serves as the area-light subtract path for the FourBitALU.
- Uses a start/busy/done handshake.
- Results are registered and held stable until the next operation is accepted.

---
 rtl/serial_subtractor.sv | 69 ++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell and a borrow flop.
// Results are registered on the edge entering DONE and held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sa, sb, sd, sd_n;
    logic [CW-1:0] count;
    logic bflop, d, bo, accept, last;

    always_comb begin
        d = sa[0] ^ sb[0] ^ bflop;
        bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bflop);
        sd_n = {d, sd[WIDTH-1:1]};
        last = count == CW'(WIDTH-1);
        accept = start && state != SHIFT;
        state_n = state == SHIFT ? (last ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
    end

    assign busy = state == SHIFT;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa <= '0;
            sb <= '0;
            sd <= '0;
            bflop <= 1'b0;
            count <= '0;
            diff <= '0;
            borrow <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            sa <= a;
            sb <= b;
            sd <= '0;
            bflop <= 1'b0;
            count <= '0;
        end else if (state == SHIFT) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sd <= sd_n;
            bflop <= bo;
            count <= count + 1'b1;
            if (last) begin
                diff <= sd_n;
                borrow <= bo;
                zero <= sd_n == '0;
            end
        end
    end
endmodule
